nf_trace_buf: RTL and testbench

//  Synthesizable instruction-retire trace buffer for the nanoFOX CPU; hardware successor of the bench-side logger/cycle counter.

---
 rtl/nf_trace_buf.sv | 149 ++++++++++++++
 tb/tb_nf_trace_buf.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_trace_buf.sv
// nanoFOX instruction-retire trace buffer.
// Captures {cycle, pc, instr} per retire and drains oldest-first over a pop port.
module nf_trace_buf #(
  parameter int DEPTH      = 16,
  parameter int XLEN       = 32,
  parameter int CYC_W      = 32,
  parameter int MAX_CYCLES = 200
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cpu_en,
  input  logic [XLEN-1:0]          instr_addr,
  input  logic [XLEN-1:0]          instr,
  input  logic [1:0]               mode,
  input  logic [XLEN-1:0]          trig_addr,
  input  logic                     arm,
  input  logic                     clr,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [1:0]               state,
  output logic                     halt_req
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = CYC_W + 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAP  = 2'd2,
    S_DONE = 2'd3
  } st_t;

  st_t               r_state;
  logic [1:0]        r_mode;
  logic [XLEN-1:0]   r_trig;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CYC_W-1:0]  r_cyc;
  logic              r_ovf;
  logic              r_rd_valid;
  logic [CYC_W-1:0]  r_rd_cycle;
  logic [XLEN-1:0]   r_rd_pc;
  logic [XLEN-1:0]   r_rd_instr;
  logic [EW-1:0]     r_mem [DEPTH];

  logic              w_empty;
  logic              w_full;
  logic              w_circ;
  logic              w_rd;
  logic              w_hit;
  logic              w_wr;
  logic              w_drop;
  logic              w_lim;
  logic              w_fill;
  logic [CYC_W-1:0]  w_cyc_nxt;
  logic [CW-1:0]     w_cnt_nxt;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_circ    = (r_mode == 2'b01);
  assign w_rd      = rd_req && !w_empty;
  assign w_hit     = (r_state == S_WAIT) && (instr_addr == r_trig);
  assign w_wr      = cpu_en && ((r_state == S_CAP) || w_hit);
  // Full write without a pop: only circular mode gets here; drop oldest
  assign w_drop    = w_wr && w_full && !w_rd;
  assign w_cyc_nxt = r_cyc + CYC_W'(1);
  assign w_lim     = (MAX_CYCLES != 0) &&
                     (w_cyc_nxt == CYC_W'(MAX_CYCLES));
  assign w_fill    = !w_circ && (w_cnt_nxt == CW'(DEPTH));

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr && !w_rd && !w_full)
      w_cnt_nxt = r_count + CW'(1);
    else if (w_rd && !w_wr)
      w_cnt_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= {r_cyc, instr_addr, instr};
  end

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'b00;
      r_trig     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cyc      <= '0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_cycle <= '0;
      r_rd_pc    <= '0;
      r_rd_instr <= '0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd)
        {r_rd_cycle, r_rd_pc, r_rd_instr} <= r_mem[r_rd_ptr];
      if (w_rd || w_drop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_cyc    <= w_cyc_nxt;
      end
      if (w_drop)
        r_ovf <= 1'b1;
      r_count <= w_cnt_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_mode  <= mode;
            r_trig  <= trig_addr;
            r_state <= (mode == 2'b10) ? S_WAIT : S_CAP;
          end
        end
        S_WAIT, S_CAP: begin
          if (w_wr)
            r_state <= (w_lim || w_fill) ? S_DONE : S_CAP;
        end
        default: ;
      endcase
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_cycle = r_rd_cycle;
  assign rd_pc    = r_rd_pc;
  assign rd_instr = r_rd_instr;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overflow = r_ovf;
  assign state    = r_state;
  assign halt_req = (r_state == S_DONE);

endmodule

// File: tb/tb_nf_trace_buf.sv
// Self-checking bench for nf_trace_buf.
// Two instances: A (DEPTH=4, unlimited) and B (DEPTH=16, MAX_CYCLES=3).
module tb_nf_trace_buf;

  localparam int A_DEPTH = 4;
  localparam int A_MAX   = 0;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_CAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_en = 1'b0;
  logic [31:0] instr_addr = '0;
  logic [31:0] instr = '0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] trig_addr = '0;
  logic        arm = 1'b0;
  logic        clr = 1'b0;
  logic        rd_req = 1'b0;

  logic        a_rd_valid, a_empty, a_full, a_overflow, a_halt;
  logic [31:0] a_rd_cycle, a_rd_pc, a_rd_instr;
  logic [2:0]  a_count;
  logic [1:0]  a_state;
  logic        b_rd_valid, b_empty, b_full, b_overflow, b_halt;
  logic [31:0] b_rd_cycle, b_rd_pc, b_rd_instr;
  logic [4:0]  b_count;
  logic [1:0]  b_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nf_trace_buf #(.DEPTH(4), .XLEN(32), .CYC_W(32), .MAX_CYCLES(0)) u_a (
    .clk(clk), .resetn(resetn), .cpu_en(cpu_en),
    .instr_addr(instr_addr), .instr(instr), .mode(mode),
    .trig_addr(trig_addr), .arm(arm), .clr(clr), .rd_req(rd_req),
    .rd_valid(a_rd_valid), .rd_cycle(a_rd_cycle), .rd_pc(a_rd_pc),
    .rd_instr(a_rd_instr), .count(a_count), .empty(a_empty),
    .full(a_full), .overflow(a_overflow), .state(a_state),
    .halt_req(a_halt)
  );

  nf_trace_buf #(.DEPTH(16), .XLEN(32), .CYC_W(32), .MAX_CYCLES(3)) u_b (
    .clk(clk), .resetn(resetn), .cpu_en(cpu_en),
    .instr_addr(instr_addr), .instr(instr), .mode(mode),
    .trig_addr(trig_addr), .arm(arm), .clr(clr), .rd_req(rd_req),
    .rd_valid(b_rd_valid), .rd_cycle(b_rd_cycle), .rd_pc(b_rd_pc),
    .rd_instr(b_rd_instr), .count(b_count), .empty(b_empty),
    .full(b_full), .overflow(b_overflow), .state(b_state),
    .halt_req(b_halt)
  );

  // Reference model of instance A: a queue of captured entries
  typedef struct {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [1:0]  m_state = ST_IDLE;
  logic [1:0]  m_mode = 2'b00;
  logic [31:0] m_trig = '0;
  logic [31:0] m_cyc = '0;
  bit          m_ovf = 1'b0;
  bit          m_rdv = 1'b0;
  ent_t        m_rd = '{cyc: 32'd0, pc: 32'd0, ins: 32'd0};

  task automatic model_cycle();
    bit do_rd;
    bit do_wr;
    m_rdv = 1'b0;
    if (!resetn || clr) begin
      mq.delete();
      m_state = ST_IDLE;
      m_mode  = 2'b00;
      m_cyc   = '0;
      m_ovf   = 1'b0;
      m_rd    = '{cyc: 32'd0, pc: 32'd0, ins: 32'd0};
      return;
    end
    do_rd = rd_req && (mq.size() != 0);
    do_wr = cpu_en && ((m_state == ST_CAP) ||
            (m_state == ST_WAIT && instr_addr == m_trig));
    if (do_rd) begin
      m_rd  = mq[0];
      mq.delete(0);
      m_rdv = 1'b1;
    end
    if (do_wr) begin
      mq.push_back('{cyc: m_cyc, pc: instr_addr, ins: instr});
      m_cyc = m_cyc + 1;
      if (mq.size() > A_DEPTH) begin
        mq.delete(0);
        m_ovf = 1'b1;
      end
      if (A_MAX != 0 && m_cyc == A_MAX)
        m_state = ST_DONE;
      else if (m_mode != 2'b01 && mq.size() == A_DEPTH)
        m_state = ST_DONE;
      else
        m_state = ST_CAP;
    end else if (m_state == ST_IDLE && arm) begin
      m_mode  = mode;
      m_trig  = trig_addr;
      m_state = (mode == 2'b10) ? ST_WAIT : ST_CAP;
    end
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] md, input logic [31:0] ta);
    mode = md;
    trig_addr = ta;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc);
    cpu_en = 1'b1;
    instr_addr = pc;
    instr = pc ^ 32'h1300_0013;
    tick();
    cpu_en = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rd_req = 1'b1;
    tick();
    tick();
    rd_req = 1'b0;
    n_cmp++;
    if ({a_state, a_count, a_empty, a_full, a_overflow, a_halt, a_rd_valid}
        !== {ST_IDLE, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_flags: got st=%0d cnt=%0d e=%b f=%b o=%b h=%b v=%b",
               a_state, a_count, a_empty, a_full, a_overflow, a_halt,
               a_rd_valid);
    end
    n_cmp++;
    if ({a_rd_cycle, a_rd_pc, a_rd_instr} !== 96'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h %h %h expected zeros",
               a_rd_cycle, a_rd_pc, a_rd_instr);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_linear();
    do_clr();
    do_arm(2'b00, 32'h0);
    n_cmp++;
    if (a_state !== ST_CAP) begin
      n_err++;
      $display("FAIL lin_arm: state %0d expected %0d", a_state, ST_CAP);
    end
    for (int i = 0; i < 4; i++) retire(32'(i * 4));
    n_cmp++;
    if ({a_full, a_state, a_halt} !== {1'b1, ST_DONE, 1'b1}) begin
      n_err++;
      $display("FAIL lin_full: full=%b st=%0d halt=%b expected 1 3 1",
               a_full, a_state, a_halt);
    end
    retire(32'h100);
    n_cmp++;
    if (a_count !== 3'd4) begin
      n_err++;
      $display("FAIL lin_done_drop: count %0d expected 4", a_count);
    end
    for (int i = 0; i < 4; i++) begin
      pop();
      n_cmp++;
      if ({a_rd_valid, a_rd_cycle, a_rd_pc, a_rd_instr} !==
          {1'b1, 32'(i), 32'(i * 4), 32'(i * 4) ^ 32'h1300_0013}) begin
        n_err++;
        $display("FAIL lin_pop%0d: v=%b cyc=%0d pc=%h ins=%h", i,
                 a_rd_valid, a_rd_cycle, a_rd_pc, a_rd_instr);
      end
    end
    n_cmp++;
    if (a_empty !== 1'b1) begin
      n_err++;
      $display("FAIL lin_empty: empty %b expected 1", a_empty);
    end
    pop();
    n_cmp++;
    if ({a_rd_valid, a_rd_pc} !== {1'b0, 32'h0C}) begin
      n_err++;
      $display("FAIL lin_pop_empty: v=%b pc=%h expected 0 0000000c",
               a_rd_valid, a_rd_pc);
    end
  endtask

  task automatic test_circular();
    do_clr();
    do_arm(2'b01, 32'h0);
    for (int i = 0; i < 6; i++) retire(32'(i * 4));
    n_cmp++;
    if ({a_count, a_overflow, a_state, a_full} !==
        {3'd4, 1'b1, ST_CAP, 1'b1}) begin
      n_err++;
      $display("FAIL circ_state: cnt=%0d ovf=%b st=%0d full=%b",
               a_count, a_overflow, a_state, a_full);
    end
    for (int i = 0; i < 4; i++) begin
      pop();
      n_cmp++;
      if ({a_rd_valid, a_rd_cycle, a_rd_pc} !==
          {1'b1, 32'(i + 2), 32'((i + 2) * 4)}) begin
        n_err++;
        $display("FAIL circ_pop%0d: v=%b cyc=%0d pc=%h expected cyc=%0d",
                 i, a_rd_valid, a_rd_cycle, a_rd_pc, i + 2);
      end
    end
  endtask

  task automatic test_trigger();
    logic [1:0] exp_st [4];
    exp_st = '{ST_WAIT, ST_WAIT, ST_CAP, ST_CAP};
    do_clr();
    do_arm(2'b10, 32'h08);
    for (int i = 0; i < 4; i++) begin
      retire(32'(i * 4));
      n_cmp++;
      if (a_state !== exp_st[i]) begin
        n_err++;
        $display("FAIL trig_st%0d: state %0d expected %0d", i, a_state,
                 exp_st[i]);
      end
    end
    n_cmp++;
    if (a_count !== 3'd2) begin
      n_err++;
      $display("FAIL trig_count: count %0d expected 2", a_count);
    end
    for (int i = 0; i < 2; i++) begin
      pop();
      n_cmp++;
      if ({a_rd_cycle, a_rd_pc} !== {32'(i), 32'(8 + i * 4)}) begin
        n_err++;
        $display("FAIL trig_pop%0d: cyc=%0d pc=%h", i, a_rd_cycle, a_rd_pc);
      end
    end
  endtask

  task automatic test_max_cycles();
    do_clr();
    do_arm(2'b00, 32'h0);
    for (int i = 0; i < 5; i++) begin
      retire(32'(i * 4));
      if (i == 2) begin
        n_cmp++;
        if ({b_state, b_halt} !== {ST_DONE, 1'b1}) begin
          n_err++;
          $display("FAIL max_done: st=%0d halt=%b expected 3 1",
                   b_state, b_halt);
        end
      end
    end
    n_cmp++;
    if ({b_count, b_halt, b_full} !== {5'd3, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL max_count: cnt=%0d halt=%b full=%b expected 3 1 0",
               b_count, b_halt, b_full);
    end
    for (int i = 0; i < 3; i++) pop();
    n_cmp++;
    if ({b_empty, b_rd_cycle, b_rd_pc} !== {1'b1, 32'd2, 32'h08}) begin
      n_err++;
      $display("FAIL max_last: e=%b cyc=%0d pc=%h expected 1 2 00000008",
               b_empty, b_rd_cycle, b_rd_pc);
    end
  endtask

  task automatic test_circ_rw();
    do_clr();
    do_arm(2'b01, 32'h0);
    for (int i = 0; i < 4; i++) retire(32'h10 + 32'(i * 4));
    rd_req = 1'b1;
    retire(32'h40);
    rd_req = 1'b0;
    n_cmp++;
    if ({a_rd_valid, a_rd_cycle, a_rd_pc, a_count, a_overflow} !==
        {1'b1, 32'd0, 32'h10, 3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL rw_same: v=%b cyc=%0d pc=%h cnt=%0d ovf=%b",
               a_rd_valid, a_rd_cycle, a_rd_pc, a_count, a_overflow);
    end
    for (int i = 0; i < 4; i++) pop();
    n_cmp++;
    if ({a_rd_cycle, a_rd_pc, a_empty} !== {32'd4, 32'h40, 1'b1}) begin
      n_err++;
      $display("FAIL rw_newest: cyc=%0d pc=%h e=%b expected 4 00000040 1",
               a_rd_cycle, a_rd_pc, a_empty);
    end
  endtask

  task automatic test_reset_mid();
    do_clr();
    do_arm(2'b01, 32'h0);
    retire(32'h0);
    retire(32'h4);
    rd_req = 1'b1;
    resetn = 1'b0;
    tick();
    rd_req = 1'b0;
    resetn = 1'b1;
    n_cmp++;
    if ({a_state, a_count, a_rd_valid, a_halt} !==
        {ST_IDLE, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid: st=%0d cnt=%0d v=%b halt=%b",
               a_state, a_count, a_rd_valid, a_halt);
    end
    do_arm(2'b00, 32'h0);
    for (int i = 0; i < 4; i++) retire(32'(i * 4));
    arm = 1'b1;
    clr = 1'b1;
    tick();
    arm = 1'b0;
    clr = 1'b0;
    n_cmp++;
    if ({a_state, a_count, a_halt, a_empty} !==
        {ST_IDLE, 3'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL clr_wins: st=%0d cnt=%0d halt=%b e=%b",
               a_state, a_count, a_halt, a_empty);
    end
  endtask

  task automatic test_random();
    logic [9:0] m_flags;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      resetn     = ($urandom_range(0, 199) != 0);
      clr        = ($urandom_range(0, 99) < 2);
      arm        = ($urandom_range(0, 7) == 0);
      mode       = 2'($urandom);
      trig_addr  = 32'($urandom_range(0, 7)) << 2;
      cpu_en     = ($urandom_range(0, 2) != 0);
      instr_addr = 32'($urandom_range(0, 7)) << 2;
      instr      = $urandom;
      rd_req     = (c % 600 < 300) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 1) == 0);
      tick();
      m_flags = {m_state, 3'(mq.size()), mq.size() == 0,
                 mq.size() == A_DEPTH, m_ovf, m_state == ST_DONE, m_rdv};
      n_cmp++;
      if ({a_state, a_count, a_empty, a_full, a_overflow, a_halt,
           a_rd_valid} !== m_flags) begin
        n_err++;
        $display("FAIL rnd_flags@%0d: got %b expected %b", c,
                 {a_state, a_count, a_empty, a_full, a_overflow, a_halt,
                  a_rd_valid}, m_flags);
      end
      n_cmp++;
      if ({a_rd_cycle, a_rd_pc, a_rd_instr} !==
          {m_rd.cyc, m_rd.pc, m_rd.ins}) begin
        n_err++;
        $display("FAIL rnd_data@%0d: got %h %h %h expected %h %h %h", c,
                 a_rd_cycle, a_rd_pc, a_rd_instr, m_rd.cyc, m_rd.pc,
                 m_rd.ins);
      end
    end
    resetn = 1'b1;
    clr = 1'b0;
    arm = 1'b0;
    cpu_en = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_linear();
    test_circular();
    test_trigger();
    test_max_cycles();
    test_circ_rw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
